// File: rtl/queen_board_buffer.sv
// ---------------------------------------------------------------------------
// queen_board_buffer
//
// Double-buffered snapshot of an N-queens board, sitting between the queen
// solver (writer) and the VGA renderer (reader).
//
// The solver fills the hidden bank one row at a time. The renderer reads the
// visible bank with no clock latency. The banks swap only on a frame_start
// pulse that arrives after a full solution is written, so the display never
// shows a half-written board. The block also counts committed solutions.
//
// Optional feature (compile-time macro CLEAR_ON_COMMIT_EN):
//   defined     - at every swap the bank that becomes the new write bank is
//                 cleared, so every solution starts from an empty board.
//   not defined - the new write bank keeps the board from two commits ago.
//
// Ports
//   clk          in   1     system / pixel clock
//   reset        in   1     asynchronous, active-low reset
//   n            in   IDXW  board size (rows beyond MAXN are clipped)
//   wr_valid     in   1     solver offers {wr_row, wr_col, wr_last}
//   wr_ready     out  1     buffer can accept a row write
//   wr_row       in   IDXW  row index, 0-based
//   wr_col       in   IDXW  queen column, 1-based, 0 = empty row
//   wr_last      in   1     this beat is the final row of a solution
//   frame_start  in   1     frame-boundary pulse from the VGA timing
//   row_query    in   IDXW  display row index
//   row_result   out  IDXW  visible-bank entry for row_query (combinational)
//   result       out  CNTW  number of committed solutions (saturating)
//   commit       out  1     one-cycle pulse in the cycle after a bank swap
// ---------------------------------------------------------------------------
module queen_board_buffer #(
    parameter int MAXN = 16,
    parameter int IDXW = 5,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [IDXW-1:0] n,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [IDXW-1:0] wr_row,
    input  logic [IDXW-1:0] wr_col,
    input  logic            wr_last,
    input  logic            frame_start,
    input  logic [IDXW-1:0] row_query,
    output logic [IDXW-1:0] row_result,
    output logic [CNTW-1:0] result,
    output logic            commit
);

    localparam int AW = (MAXN > 1) ? $clog2(MAXN) : 1;
    // One extra bit so MAXN itself is representable in the row comparison.
    localparam logic [IDXW:0] MAXN_W = (IDXW + 1)'(MAXN);

    typedef enum logic [0:0] {
        FILL    = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic            disp_q, disp_d;
    logic [IDXW-1:0] n_q;
    logic [CNTW-1:0] result_q, result_d;
    logic            commit_q, commit_d;
    logic [IDXW-1:0] bank_q [0:1][0:MAXN-1];
    logic [IDXW-1:0] bank_d [0:1][0:MAXN-1];

    logic            wr_bank_s;
    logic            n_change_s;
    logic            wr_fire_s;
    logic            row_ok_s;
    logic            query_ok_s;

    assign wr_bank_s  = ~disp_q;
    assign n_change_s = (n_q != n);
    assign wr_ready   = (state_q == FILL);
    assign wr_fire_s  = wr_valid & wr_ready;
    // Comparing against n_q is equivalent to n here: whenever they differ the
    // n-change clear takes over and the write is dropped anyway.
    assign row_ok_s   = ({1'b0, wr_row} < MAXN_W) && (wr_row < n_q);
    assign query_ok_s = ({1'b0, row_query} < MAXN_W);

    assign row_result = query_ok_s ? bank_q[disp_q][row_query[AW-1:0]] : {IDXW{1'b0}};
    assign result     = result_q;
    assign commit     = commit_q;

    // Next-state logic: n-change clear has priority over writes and swaps.
    always_comb begin
        bank_d   = bank_q;
        state_d  = state_q;
        disp_d   = disp_q;
        result_d = result_q;
        commit_d = 1'b0;

        if (n_change_s) begin
            for (int i = 0; i < MAXN; i++) begin
                bank_d[wr_bank_s][i] = {IDXW{1'b0}};
            end
            result_d = {CNTW{1'b0}};
            state_d  = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (wr_fire_s) begin
                        if (row_ok_s) begin
                            bank_d[wr_bank_s][wr_row[AW-1:0]] = wr_col;
                        end else begin
                            bank_d = bank_q;
                        end
                        if (wr_last) begin
                            state_d = PENDING;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        disp_d   = ~disp_q;
                        commit_d = 1'b1;
                        state_d  = FILL;
                        if (result_q != {CNTW{1'b1}}) begin
                            result_d = result_q + {{(CNTW-1){1'b0}}, 1'b1};
                        end else begin
                            result_d = result_q;
                        end
`ifdef CLEAR_ON_COMMIT_EN
                        // The currently visible bank becomes the next write bank.
                        for (int i = 0; i < MAXN; i++) begin
                            bank_d[disp_q][i] = {IDXW{1'b0}};
                        end
`else
                        bank_d = bank_q;
`endif
                    end else begin
                        state_d = PENDING;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // State, bank storage and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= FILL;
            disp_q   <= 1'b0;
            n_q      <= {IDXW{1'b0}};
            result_q <= {CNTW{1'b0}};
            commit_q <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < MAXN; i++) begin
                    bank_q[b][i] <= {IDXW{1'b0}};
                end
            end
        end else begin
            state_q  <= state_d;
            disp_q   <= disp_d;
            n_q      <= n;
            result_q <= result_d;
            commit_q <= commit_d;
            bank_q   <= bank_d;
        end
    end

endmodule

// File: tb/tb_queen_board_buffer.sv
// ---------------------------------------------------------------------------
// tb_queen_board_buffer
//
// Directed self-checking bench for queen_board_buffer (MAXN=16, IDXW=5,
// CNTW=32). Inputs are driven one time unit after the rising edge; outputs
// are sampled #1 after the edge or on the falling edge.
// ---------------------------------------------------------------------------
module tb_queen_board_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_row;
    logic [4:0]  wr_col;
    logic        wr_last;
    logic        frame_start;
    logic [4:0]  row_query;
    logic [4:0]  row_result;
    logic [31:0] result;
    logic        commit;

    int n_cmp = 0;
    int n_mis = 0;
    int xfer_cnt = 0;
    int xfer_snap;

    queen_board_buffer #(.MAXN(16), .IDXW(5), .CNTW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .n           (n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_row      (wr_row),
        .wr_col      (wr_col),
        .wr_last     (wr_last),
        .frame_start (frame_start),
        .row_query   (row_query),
        .row_result  (row_result),
        .result      (result),
        .commit      (commit)
    );

    always #5 clk = ~clk;

    // Count handshakes seen by the bench.
    always @(posedge clk) begin
        if (wr_valid && wr_ready) xfer_cnt <= xfer_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] row, input logic [4:0] col, input logic last);
        wr_valid = 1'b1;
        wr_row   = row;
        wr_col   = col;
        wr_last  = last;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic chk_row(input string tag, input logic [4:0] q, input logic [4:0] exp);
        row_query = q;
        @(negedge clk);
        check_val(tag, {27'd0, row_result}, {27'd0, exp});
    endtask

    initial begin
        logic [4:0] sol_a [4];
        logic [4:0] sol_b [4];
        sol_a = '{5'd2, 5'd4, 5'd1, 5'd3};
        sol_b = '{5'd3, 5'd1, 5'd4, 5'd2};

        reset = 1'b0; n = 5'd8; wr_valid = 1'b0; wr_row = 5'd0; wr_col = 5'd0;
        wr_last = 1'b0; frame_start = 1'b0; row_query = 5'd0;

        // Reset state
        tick(3);
        check_val("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        check_val("rst_result", result, 32'd0);
        check_val("rst_commit", {31'd0, commit}, 32'd0);
        chk_row("rst_row0", 5'd0, 5'd0);
        chk_row("rst_row15", 5'd15, 5'd0);
        reset = 1'b1;
        tick(2);

        // First solution n=4, frame_start 5 cycles after the last row
        n = 5'd4;
        tick(2);
        for (int r = 0; r < 4; r++) wr(5'(r), sol_a[r], (r == 3));
        check_val("a_pending_ready", {31'd0, wr_ready}, 32'd0);
        tick(4);
        chk_row("a_before_row1", 5'd1, 5'd0);
        frame();
        check_val("a_commit_hi", {31'd0, commit}, 32'd1);
        check_val("a_result", result, 32'd1);
        tick(1);
        check_val("a_commit_lo", {31'd0, commit}, 32'd0);
        for (int r = 0; r < 4; r++) chk_row($sformatf("a_row%0d", r), 5'(r), sol_a[r]);

        // Second solution, then wr_valid held 100 cycles in PENDING
        for (int r = 0; r < 4; r++) wr(5'(r), sol_b[r], (r == 3));
        wr_valid = 1'b1; wr_row = 5'd0; wr_col = 5'd9; wr_last = 1'b0;
        xfer_snap = xfer_cnt;
        tick(100);
        wr_valid = 1'b0;
        check_val("hold_no_xfer", xfer_cnt - xfer_snap, 32'd0);
        check_val("hold_ready", {31'd0, wr_ready}, 32'd0);
        chk_row("hold_row0", 5'd0, 5'd2);
        frame();
        check_val("b_commit", {31'd0, commit}, 32'd1);
        check_val("b_result", result, 32'd2);
        chk_row("b_row0", 5'd0, 5'd3);
        chk_row("b_row1", 5'd1, 5'd1);

        // wr_last and frame_start in the same cycle: no swap
        for (int r = 0; r < 3; r++) wr(5'(r), 5'(r + 1), 1'b0);
        frame_start = 1'b1;
        wr(5'd3, 5'd4, 1'b1);
        frame_start = 1'b0;
        check_val("same_ready", {31'd0, wr_ready}, 32'd0);
        check_val("same_result", result, 32'd2);
        check_val("same_commit", {31'd0, commit}, 32'd0);
        chk_row("same_row0", 5'd0, 5'd3);
        tick(2);
        frame();
        check_val("c_commit", {31'd0, commit}, 32'd1);
        check_val("c_result", result, 32'd3);
        chk_row("c_row0", 5'd0, 5'd1);
        chk_row("c_row3", 5'd3, 5'd4);

        // Out-of-range row is accepted but discarded
        check_val("oor_ready_pre", {31'd0, wr_ready}, 32'd1);
        xfer_snap = xfer_cnt;
        wr(5'd6, 5'd2, 1'b0);
        check_val("oor_xfer", xfer_cnt - xfer_snap, 32'd1);
        check_val("oor_ready_post", {31'd0, wr_ready}, 32'd1);
        chk_row("oor_q20", 5'd20, 5'd0);
        wr(5'd0, 5'd7, 1'b1);
        frame();
        check_val("d_result", result, 32'd4);
        chk_row("d_row0", 5'd0, 5'd7);
`ifdef CLEAR_ON_COMMIT_EN
        chk_row("d_row1", 5'd1, 5'd0);
        chk_row("d_row2", 5'd2, 5'd0);
        chk_row("d_row3", 5'd3, 5'd0);
`else
        chk_row("d_row1", 5'd1, 5'd1);
        chk_row("d_row2", 5'd2, 5'd4);
        chk_row("d_row3", 5'd3, 5'd2);
`endif
        chk_row("d_row6", 5'd6, 5'd0);
        chk_row("d_q20", 5'd20, 5'd0);

        // n -> 8 clears the count; two commits; then n 8->5 with frame_start
        n = 5'd8;
        tick(2);
        check_val("n8_result", result, 32'd0);
        chk_row("n8_row0", 5'd0, 5'd7);
        for (int r = 0; r < 8; r++) wr(5'(r), 5'(r + 1), (r == 7));
        frame();
        check_val("e_result", result, 32'd1);
        chk_row("e_row7", 5'd7, 5'd8);
        for (int r = 0; r < 8; r++) wr(5'(r), 5'(8 - r), (r == 7));
        frame();
        check_val("f_result", result, 32'd2);
        chk_row("f_row0", 5'd0, 5'd8);
        wr(5'd0, 5'd5, 1'b1);
        check_val("g_pending", {31'd0, wr_ready}, 32'd0);
        n = 5'd5;
        frame();
        check_val("nchg_result", result, 32'd0);
        check_val("nchg_ready", {31'd0, wr_ready}, 32'd1);
        check_val("nchg_commit", {31'd0, commit}, 32'd0);
        chk_row("nchg_row0", 5'd0, 5'd8);
        chk_row("nchg_row7", 5'd7, 5'd1);

        // Reset asserted mid-PENDING
        wr(5'd0, 5'd3, 1'b1);
        check_val("h_pending", {31'd0, wr_ready}, 32'd0);
        reset = 1'b0;
        #1;
        check_val("mrst_ready", {31'd0, wr_ready}, 32'd1);
        check_val("mrst_result", result, 32'd0);
        check_val("mrst_commit", {31'd0, commit}, 32'd0);
        chk_row("mrst_row0", 5'd0, 5'd0);
        chk_row("mrst_row7", 5'd7, 5'd0);
        reset = 1'b1;
        tick(3);
        wr(5'd0, 5'd6, 1'b1);
        frame();
        check_val("post_rst_result", result, 32'd1);
        chk_row("post_rst_row0", 5'd0, 5'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
